// File: rtl/tpu_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tpu_ctrl
// Brief   : Host bus decoder and matmul sequencer for the TPU datapath.
// Revision: 1.0 - initial release
// ============================================================================
module tpu_ctrl #(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int DIM     = 8,
    parameter int ADDRW   = 16,
    parameter int DATAW   = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     r_w,
    input  logic [ADDRW-1:0]         addr,
    input  logic [DATAW-1:0]         dataIn,
    output logic                     mema_en,
    output logic                     mema_wren,
    output logic [$clog2(DIM)-1:0]   mema_row,
    output logic                     memb_en,
    output logic                     sa_en,
    output logic                     sa_wren,
    output logic [$clog2(DIM)-1:0]   sa_crow,
    output logic [DATAW-1:0]         c_lo,
    output logic [1:0]               rd_sel,
    output logic                     busy,
    output logic                     done
);

    localparam int LG = $clog2(DIM);
    localparam int CW = $clog2(3*DIM-2);
    localparam logic [CW-1:0] c_last = CW'(3*DIM-3);
    localparam logic [7:0] c_reg_a   = 8'h01;
    localparam logic [7:0] c_reg_b   = 8'h02;
    localparam logic [7:0] c_reg_c   = 8'h03;
    localparam logic [7:0] c_reg_ctl = 8'h04;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_lo_valid;

    logic [7:0]      w_region;
    logic            w_is_a, w_is_b, w_is_c, w_is_ctl, w_start, w_half;
    logic [LG-1:0]   w_arow, w_crow;

    assign w_region = addr[15:8];
    assign w_is_a   = (w_region == c_reg_a);
    assign w_is_b   = (w_region == c_reg_b);
    assign w_is_c   = (w_region == c_reg_c);
    assign w_is_ctl = (w_region == c_reg_ctl);
    assign w_start  = w_is_ctl & r_w & dataIn[0];
    assign w_half   = addr[3];
    assign w_arow   = addr[3 +: LG];
    assign w_crow   = addr[4 +: LG];

    // Keeps geometry parameters and untouched address bits referenced.
    logic w_unused;
    assign w_unused = (^addr) ^ (DIM*BITS_C == 2*DATAW) ^ (DIM*BITS_AB == DATAW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_lo_valid <= 1'b0;
            mema_en    <= 1'b0;
            mema_wren  <= 1'b0;
            mema_row   <= '0;
            memb_en    <= 1'b0;
            sa_en      <= 1'b0;
            sa_wren    <= 1'b0;
            sa_crow    <= '0;
            c_lo       <= '0;
            rd_sel     <= 2'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            mema_wren <= 1'b0;
            sa_wren   <= 1'b0;
            done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    mema_en <= 1'b0;
                    memb_en <= 1'b0;
                    sa_en   <= 1'b0;
                    busy    <= 1'b0;
                    if (r_w) begin
                        if (w_is_a) begin
                            mema_wren <= 1'b1;
                            mema_row  <= w_arow;
                        end
                        if (w_is_b)
                            memb_en <= 1'b1;
                        // A C row is assembled from two beats; high half without low is dropped.
                        if (w_is_c) begin
                            if (!w_half) begin
                                c_lo       <= dataIn;
                                r_lo_valid <= 1'b1;
                            end else if (r_lo_valid) begin
                                sa_wren    <= 1'b1;
                                sa_crow    <= w_crow;
                                r_lo_valid <= 1'b0;
                            end
                        end
                        if (w_start) begin
                            r_state <= S_RUN;
                            r_cnt   <= '0;
                            busy    <= 1'b1;
                            mema_en <= 1'b1;
                            memb_en <= 1'b1;
                            sa_en   <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (r_cnt == c_last) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        mema_en <= 1'b0;
                        memb_en <= 1'b0;
                        sa_en   <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // Reads decode in both states so status stays observable mid-run.
            if (!r_w) begin
                if (w_is_c) begin
                    sa_crow <= w_crow;
                    rd_sel  <= w_half ? 2'd2 : 2'd1;
                end else if (w_is_ctl) begin
                    rd_sel <= 2'd0;
                end
            end
        end
    end

endmodule
`default_nettype wire
